// File: rtl/rate_step_ctrl.sv
// Step-rate controller: faster/slower buttons step a clamped delay exponent and a
// prescaler emits tick every 2^delay clocks. Define RATE_STEP_CTRL_AUTOREPEAT_EN for hold-to-repeat.
module rate_step_ctrl #(
  parameter int unsigned WIDTH        = 4,
  parameter int unsigned MIN          = 9,
  parameter int unsigned MAX          = 15,
  parameter int unsigned INIT         = 12,
  parameter int unsigned REPEAT_DELAY = 25_000_000,
  parameter int unsigned REPEAT_RATE  = 5_000_000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             faster,
  input  logic             slower,
  output logic [WIDTH-1:0] delay,
  output logic             tick,
  output logic             at_min,
  output logic             at_max,
  output logic             changed
);

  localparam int unsigned PCNT_W = MAX;
  localparam logic [WIDTH-1:0] MIN_V  = WIDTH'(MIN);
  localparam logic [WIDTH-1:0] MAX_V  = WIDTH'(MAX);
  localparam logic [WIDTH-1:0] INIT_V = WIDTH'(INIT);

  // Elaboration-time parameter sanity checks
  if (!((MIN <= INIT) && (INIT <= MAX) && (MAX < (1 << WIDTH)))) begin : g_bad_range
    $error("rate_step_ctrl: MIN <= INIT <= MAX < 2**WIDTH violated");
  end
  if ((MAX > 30) || (MAX < 1)) begin : g_bad_max
    $error("rate_step_ctrl: MAX must be within 1..30");
  end
  if ((REPEAT_DELAY < 2) || (REPEAT_RATE < 1)) begin : g_bad_repeat
    $error("rate_step_ctrl: REPEAT_DELAY >= 2 and REPEAT_RATE >= 1 required");
  end

  logic              r_f_q;
  logic              r_s_q;
  logic [WIDTH-1:0]  r_delay;
  logic              r_tick;
  logic              r_at_min;
  logic              r_at_max;
  logic              r_changed;
  logic [PCNT_W-1:0] r_pcnt;

  logic              w_rise_f;
  logic              w_rise_s;
  logic              w_step_dn;
  logic              w_step_up;
  logic [WIDTH-1:0]  w_delay_nxt;
  logic              w_chg;
  logic [PCNT_W-1:0] w_pmask;
  logic              w_pterm;

  assign w_rise_f = faster & ~r_f_q;
  assign w_rise_s = slower & ~r_s_q;

`ifdef RATE_STEP_CTRL_AUTOREPEAT_EN
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_HOLD   = 2'd1;
  localparam logic [1:0] ST_REPEAT = 2'd2;
  localparam logic       DIR_DN    = 1'b0;
  localparam logic       DIR_UP    = 1'b1;

  localparam int unsigned RCNT_SPAN = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int unsigned RCNT_W    = (RCNT_SPAN > 2) ? $clog2(RCNT_SPAN) : 1;
  localparam logic [RCNT_W-1:0] RD_LAST = RCNT_W'(REPEAT_DELAY - 1);
  localparam logic [RCNT_W-1:0] RR_LAST = RCNT_W'(REPEAT_RATE - 1);

  logic [1:0]        r_state;
  logic              r_dir;
  logic [RCNT_W-1:0] r_rcnt;

  logic [1:0]        w_state_nxt;
  logic              w_dir_nxt;
  logic [RCNT_W-1:0] w_rcnt_nxt;
  logic              w_dir_btn;
  logic [RCNT_W-1:0] w_rcnt_last;

  assign w_dir_btn   = (r_dir == DIR_DN) ? faster : slower;
  assign w_rcnt_last = (r_state == ST_HOLD) ? RD_LAST : RR_LAST;

  // Repeat FSM: next state, direction, counter and step requests
  always_comb begin
    w_state_nxt = r_state;
    w_dir_nxt   = r_dir;
    w_rcnt_nxt  = r_rcnt;
    w_step_dn   = 1'b0;
    w_step_up   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_rcnt_nxt = '0;
        if (w_rise_f && !slower) begin
          w_step_dn   = 1'b1;
          w_dir_nxt   = DIR_DN;
          w_state_nxt = ST_HOLD;
        end else if (w_rise_s && !faster) begin
          w_step_up   = 1'b1;
          w_dir_nxt   = DIR_UP;
          w_state_nxt = ST_HOLD;
        end
      end
      ST_HOLD, ST_REPEAT: begin
        if (faster && slower) begin
          w_state_nxt = ST_IDLE;
          w_rcnt_nxt  = '0;
        end else if (!w_dir_btn) begin
          // Release of the held button with the other rising at once swaps direction
          w_rcnt_nxt = '0;
          if ((r_dir == DIR_DN) && w_rise_s) begin
            w_step_up   = 1'b1;
            w_dir_nxt   = DIR_UP;
            w_state_nxt = ST_HOLD;
          end else if ((r_dir == DIR_UP) && w_rise_f) begin
            w_step_dn   = 1'b1;
            w_dir_nxt   = DIR_DN;
            w_state_nxt = ST_HOLD;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end else if (r_rcnt == w_rcnt_last) begin
          w_step_dn   = (r_dir == DIR_DN);
          w_step_up   = (r_dir == DIR_UP);
          w_rcnt_nxt  = '0;
          w_state_nxt = ST_REPEAT;
        end else begin
          w_rcnt_nxt = r_rcnt + RCNT_W'(1);
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_rcnt_nxt  = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_dir   <= DIR_DN;
      r_rcnt  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_dir   <= w_dir_nxt;
      r_rcnt  <= w_rcnt_nxt;
    end
  end
`else
  // Edge-only stepping: a held button steps exactly once
  always_comb begin
    w_step_dn = w_rise_f & ~slower;
    w_step_up = w_rise_s & ~faster;
  end
`endif

  // Saturating delay update
  always_comb begin
    w_delay_nxt = r_delay;
    if (w_step_dn && (r_delay != MIN_V)) begin
      w_delay_nxt = r_delay - WIDTH'(1);
    end else if (w_step_up && (r_delay != MAX_V)) begin
      w_delay_nxt = r_delay + WIDTH'(1);
    end
  end

  assign w_chg   = (w_delay_nxt != r_delay);
  assign w_pmask = ~({PCNT_W{1'b1}} << r_delay);
  assign w_pterm = (r_pcnt == w_pmask);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_f_q     <= faster;
      r_s_q     <= slower;
      r_delay   <= INIT_V;
      r_tick    <= 1'b0;
      r_changed <= 1'b0;
      r_at_min  <= (INIT_V == MIN_V);
      r_at_max  <= (INIT_V == MAX_V);
      r_pcnt    <= '0;
    end else begin
      r_f_q     <= faster;
      r_s_q     <= slower;
      r_delay   <= w_delay_nxt;
      r_changed <= w_chg;
      r_at_min  <= (w_delay_nxt == MIN_V);
      r_at_max  <= (w_delay_nxt == MAX_V);
      // A delay change restarts the period and suppresses the pending tick
      if (w_chg) begin
        r_pcnt <= '0;
        r_tick <= 1'b0;
      end else if (w_pterm) begin
        r_pcnt <= '0;
        r_tick <= 1'b1;
      end else begin
        r_pcnt <= r_pcnt + PCNT_W'(1);
        r_tick <= 1'b0;
      end
    end
  end

  assign delay   = r_delay;
  assign tick    = r_tick;
  assign at_min  = r_at_min;
  assign at_max  = r_at_max;
  assign changed = r_changed;

endmodule

// File: tb/tb_rate_step_ctrl.sv
// Directed bench for rate_step_ctrl: a scoreboard queue holds the expected delay/flags
// for every changed pulse; tick spacing and hold behaviour are checked against a small model.
`timescale 1ns/1ps
module tb_rate_step_ctrl;

  localparam int WIDTH  = 4;
  localparam int MIN_D  = 9;
  localparam int MAX_D  = 15;
  localparam int INIT_D = 12;
  localparam int RD     = 8;
  localparam int RR     = 4;

  typedef struct {
    int d;
    int mn;
    int mx;
  } exp_t;

  logic             clk    = 1'b0;
  logic             reset  = 1'b1;
  logic             faster = 1'b0;
  logic             slower = 1'b0;
  logic [WIDTH-1:0] delay;
  logic             tick;
  logic             at_min;
  logic             at_max;
  logic             changed;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  int   cur      = INIT_D;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  rate_step_ctrl #(
    .WIDTH(WIDTH), .MIN(MIN_D), .MAX(MAX_D), .INIT(INIT_D),
    .REPEAT_DELAY(RD), .REPEAT_RATE(RR)
  ) dut (
    .clk(clk), .reset(reset), .faster(faster), .slower(slower),
    .delay(delay), .tick(tick), .at_min(at_min), .at_max(at_max), .changed(changed)
  );

  task automatic check(input string tag, input int obs, input int expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  function automatic int step_model(input int d, input bit up);
    if (up) return (d < MAX_D) ? d + 1 : d;
    return (d > MIN_D) ? d - 1 : d;
  endfunction

  function automatic int hold_model(input int j);
`ifdef RATE_STEP_CTRL_AUTOREPEAT_EN
    int v;
    v = 13 + ((j >= RD) ? 1 : 0) + ((j >= RD + RR) ? 1 : 0);
    return (v > MAX_D) ? MAX_D : v;
`else
    if (j < 0) return INIT_D;
    return 13;
`endif
  endfunction

  task automatic expect_step(input bit up);
    int n;
    n = step_model(cur, up);
    if (n != cur) exp_q.push_back('{n, int'(n == MIN_D), int'(n == MAX_D)});
    cur = n;
  endtask

  task automatic pulse_btn(input bit up, input string tag);
    expect_step(up);
    if (up) slower = 1'b1; else faster = 1'b1;
    @(negedge clk);
    faster = 1'b0;
    slower = 1'b0;
    repeat (2) @(negedge clk);
    check(tag, int'(delay), cur);
  endtask

  task automatic wait_tick(output int c);
    int n;
    n = 0;
    @(negedge clk);
    while (tick !== 1'b1 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check("tick_seen", int'(tick), 1);
    c = cyc;
  endtask

  // Scoreboard: every changed pulse must match the oldest expected step
  always @(negedge clk) begin : monitor
    exp_t e;
    if (changed === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("changed_unexpected", int'(changed), 0);
      end else begin
        e = exp_q.pop_front();
        check("sb_delay", int'(delay), e.d);
        check("sb_at_min", int'(at_min), e.mn);
        check("sb_at_max", int'(at_max), e.mx);
      end
    end
  end

  initial begin
    #500_000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int c0, c1, c2, cs;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    c0 = cyc;
    check("rst_delay", int'(delay), INIT_D);
    check("rst_at_min", int'(at_min), 0);
    check("rst_at_max", int'(at_max), 0);
    check("rst_tick", int'(tick), 0);
    check("rst_changed", int'(changed), 0);

    wait_tick(c1);
    check("first_tick_12", c1 - c0, 4096);
    wait_tick(c2);
    check("tick_period_12", c2 - c1, 4096);

    pulse_btn(1'b0, "faster_1");
    pulse_btn(1'b0, "faster_2");
    pulse_btn(1'b0, "faster_3");
    check("at_min_after_3", int'(at_min), 1);
    pulse_btn(1'b0, "faster_at_min");
    check("at_min_held", int'(at_min), 1);

    wait_tick(c1);
    wait_tick(c2);
    check("tick_period_9", c2 - c1, 512);
    repeat (100) @(negedge clk);
    expect_step(1'b1);
    slower = 1'b1;
    @(negedge clk);
    cs = cyc;
    check("mid_step_changed", int'(changed), 1);
    slower = 1'b0;
    wait_tick(c1);
    check("tick_after_step", c1 - cs, 1024);
    wait_tick(c2);
    check("tick_period_10", c2 - c1, 1024);

    pulse_btn(1'b1, "slower_11");
    pulse_btn(1'b1, "slower_12");

`ifdef RATE_STEP_CTRL_AUTOREPEAT_EN
    repeat (3) expect_step(1'b1);
`else
    expect_step(1'b1);
`endif
    slower = 1'b1;
    for (int j = 0; j < 20; j++) begin
      @(negedge clk);
      check("hold_slower", int'(delay), hold_model(j));
    end
    slower = 1'b0;
    repeat (3) @(negedge clk);
    check("hold_at_max", int'(at_max), int'(cur == MAX_D));

    pulse_btn(1'b0, "pre_both_1");
    pulse_btn(1'b0, "pre_both_2");
    faster = 1'b1;
    slower = 1'b1;
    repeat (4) @(negedge clk);
    check("both_no_step", int'(delay), cur);
    faster = 1'b0;
    slower = 1'b0;
    repeat (2) @(negedge clk);

    expect_step(1'b1);
    slower = 1'b1;
    repeat (3) @(negedge clk);
    faster = 1'b1;
    repeat (3) @(negedge clk);
    check("hold_then_both", int'(delay), cur);
    faster = 1'b0;
    repeat (12) @(negedge clk);
    check("idle_after_both", int'(delay), cur);
    slower = 1'b0;
    repeat (2) @(negedge clk);

    expect_step(1'b0);
    faster = 1'b1;
    repeat (3) @(negedge clk);
    expect_step(1'b1);
    faster = 1'b0;
    slower = 1'b1;
    repeat (2) @(negedge clk);
    check("swap_step", int'(delay), cur);
    slower = 1'b0;
    repeat (2) @(negedge clk);

    faster = 1'b1;
    reset  = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    cur   = INIT_D;
    check("reset_hold_delay", int'(delay), INIT_D);
    repeat (12) @(negedge clk);
    check("held_through_reset", int'(delay), INIT_D);
    faster = 1'b0;
    repeat (2) @(negedge clk);

    check("scoreboard_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rate_step_ctrl.md
# rate_step_ctrl

Parametrised step-rate controller for the blink/scroll demos. Two pushbutton requests (`faster`, `slower`) step a clamped delay exponent, with optional hold-to-auto-repeat. An integrated prescaler emits a one-cycle `tick` every 2^`delay` clocks. It replaces a fixed 4-bit delay register plus an external divider, and feeds LED/hex animation logic directly.

## Interface
- `WIDTH`, 4: width of `delay`.
- `MIN`, 9: lowest allowed `delay` (fastest rate).
- `MAX`, 15: highest allowed `delay` (slowest rate).
  - Constraint: MIN ≤ INIT ≤ MAX < 2^WIDTH.
  - Constraint: MAX ≤ 30.
- `INIT`, 12: `delay` value after reset.
- `REPEAT_DELAY`, 25_000_000: hold cycles before auto-repeat starts. Must be ≥ 2.
- `REPEAT_RATE`, 5_000_000: cycles between auto-repeat steps. Must be ≥ 1.
- `clk`  in  1  clock; all logic on the rising edge.
- `reset`  in  1  reset, synchronous, active-high.
- `faster`  in  1  request to decrement `delay`. Level input, already synchronised and debounced.
- `slower`  in  1  request to increment `delay`. Level input, already synchronised and debounced.
- `delay`  out  WIDTH  current exponent (registered).
- `tick`  out  1  one-cycle pulse every 2^`delay` cycles.
- `at_min`  out  1  high while `delay` == MIN.
- `at_max`  out  1  high while `delay` == MAX.
- `changed`  out  1  one-cycle pulse on the clock edge after `delay` took a new value.

## Operation
- Edge detect
  - Registers `f_q` and `s_q` hold the previous-cycle `faster` and `slower`.
  - During reset, `f_q`/`s_q` load the live inputs. A button held through reset release therefore produces no step.
  - `rise_f` = `faster` & !`f_q`; `rise_s` = `slower` & !`s_q`.
- Step rule
  - A step fires only when exactly one button is high.
  - Down step: `faster` high and `slower` low → `delay` -1, saturating at MIN.
  - Up step: `slower` high and `faster` low → `delay` +1, saturating at MAX.
  - Both high → no step in any state; the FSM goes to IDLE.
  - A step at a limit leaves `delay` unchanged, and no `changed` pulse is generated.
- Repeat FSM, states IDLE, HOLD, REPEAT
  - State register holds `dir` (DN/UP) and counter `rcnt` (width $clog2(REPEAT_DELAY)).
  - IDLE: on a qualifying rise (`rise_f` or `rise_s`, other button low) → step once, `dir` ← that button, `rcnt` ← 0, go to HOLD.
  - HOLD: while only the `dir` button is high, `rcnt` increments. When `rcnt` == REPEAT_DELAY-1 → step, `rcnt` ← 0, go to REPEAT.
  - REPEAT: same hold condition. When `rcnt` == REPEAT_RATE-1 → step, `rcnt` ← 0, stay in REPEAT.
  - HOLD/REPEAT exit, `dir` button released or both buttons high → IDLE.
  - HOLD/REPEAT direction swap: the `dir` button is released and the other button rises in the same cycle → treated as an IDLE qualifying rise. Step in the new direction, go to HOLD.
- Prescaler
  - Counter `pcnt`, MAX bits wide.
  - `tick` is asserted in the cycle after `pcnt` == 2^`delay` - 1. Then `pcnt` ← 0.
  - On any cycle where `delay` changes, `pcnt` ← 0 and no tick is issued for that terminal count.
- Flags: `at_min`/`at_max` are registered and updated together with `delay`.

## Timing
- Reset values
  - `delay` = INIT.
  - `tick` = 0, `changed` = 0.
  - `at_min` = (INIT == MIN); `at_max` = (INIT == MAX).
  - FSM = IDLE, `rcnt` = 0, `pcnt` = 0.
- Step latency: input rise sampled at edge k → new `delay` visible after edge k. `changed` is high for the cycle after edge k.
- Auto-repeat step times, for a button first sampled high at edge k:
  - First repeat at edge k+REPEAT_DELAY.
  - Subsequent repeats every REPEAT_RATE edges.
- Tick spacing with a constant `delay` = d: exactly 2^d cycles between tick rising edges.
- Reset mid-hold or mid-repeat: the next cycle is IDLE with `delay` = INIT. No step occurs until the button is released and pressed again.

## Configuration
- `RATE_STEP_CTRL_AUTOREPEAT_EN`
  - Defined: the HOLD/REPEAT behaviour above is compiled in.
  - Undefined: HOLD and REPEAT, `rcnt`, and the REPEAT_* logic are removed. Only qualifying rising edges step `delay`; a held button gives exactly one step. REPEAT_* parameters are accepted and ignored.

## Test plan
Bench overrides: REPEAT_DELAY=8, REPEAT_RATE=4; all other parameters default.
- Reset release with no buttons → `delay`=12, `at_min`=0, `at_max`=0. `tick` every 4096 cycles.
- Pulse `faster` 1 cycle, three separate times → `delay` 11, 10, 9. `changed` pulses 3×, `at_min`=1. A fourth press gives `delay`=9 and no `changed`.
- Hold `slower` from `delay`=12 for 20 cycles (macro defined) → steps at cycles 0, 8, 12, 16 → `delay` 13, 14, 15, 15. `at_max`=1 after the third step.
- Same 20-cycle hold with the macro undefined → a single step, `delay`=13.
- Assert both buttons together; then from HOLD on `slower`, assert `faster` → no step; FSM goes to IDLE, `delay` unchanged.
- With `delay`=9, tick period 512: step to 10 mid-period → `pcnt` clears. Next tick comes 1024 cycles after the step; later ticks are 1024 apart. Hold `faster` through reset → `delay`=12, no step after reset release.
